keypad_entry_ctrl: RTL and testbench
====================================

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter MAX_DIGITS, default 6: maximum digits per entry.
REQ-002 Parameter VALUE_W, default 20: width of the binary entry value; it SHALL be at least ceil(log2(10^MAX_DIGITS)).
REQ-003 Parameter RELEASE_CYCLES, default 4: number of consecutive idle-code cycles that count as a key release.
REQ-004 clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 key_code  input  4  keypad code: 0-9 digit, 10 '*', 11 '#', 13 idle; all other values SHALL be ignored and treated as idle.
REQ-007 enable  input  1  entry armed; when low the block SHALL ignore keys.
REQ-008 entry_ready  input  1  consumer accepts the completed entry.
REQ-009 key_ack  output  1  one-cycle pulse when a key is accepted.
REQ-010 entry_valid  output  1  completed entry pending.
REQ-011 entry_value  output  VALUE_W  binary value of the entry.
REQ-012 digits_bcd  output  4*MAX_DIGITS  live BCD digits for display; the newest digit SHALL be in bits [3:0].
REQ-013 digit_count  output  clog2(MAX_DIGITS+1)  number of digits currently entered.
REQ-014 err  output  1  one-cycle pulse when a key is rejected.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, APPLY, RELEASE, HOLD.
REQ-016 IDLE: when enable=1 and key_code is 0-11, the block SHALL register the code and go to APPLY on the next edge.
REQ-017 APPLY lasts one cycle, and in it the block SHALL do all of the following:
- assert key_ack for that cycle;
- apply the key as defined in REQ-018 to REQ-021;
- go to HOLD if '#' was accepted, otherwise to RELEASE.
REQ-018 Digit d with digit_count<MAX_DIGITS:
- entry_value <= entry_value*10+d, built from shifts and adds with no multiplier;
- digits_bcd <= {digits_bcd shifted left by 4 bits, d};
- digit_count increments.
REQ-019 Digit with digit_count==MAX_DIGITS: all state SHALL be unchanged and err SHALL pulse in the APPLY cycle.
REQ-020 '*': entry_value, digits_bcd and digit_count SHALL all clear; err SHALL not pulse.
REQ-021 '#' handling:
- digit_count==0: err SHALL pulse, no state changes, and the FSM goes to RELEASE;
- otherwise entry_valid SHALL rise in the cycle after APPLY.
REQ-022 RELEASE: a counter SHALL count consecutive idle cycles of key_code; any code 0-11 SHALL reset the counter to 0; the FSM returns to IDLE when the count reaches RELEASE_CYCLES.
REQ-023 HOLD: entry_valid=1, and entry_value and digit_count SHALL stay stable; keys SHALL be neither acknowledged nor applied.
REQ-024 When entry_valid=1 and entry_ready=1 on the same edge:
- entry_value, digits_bcd and digit_count SHALL clear;
- entry_valid SHALL drop;
- the FSM SHALL go to RELEASE, so the held '#' must be released first.
REQ-025 entry_valid SHALL NOT drop without entry_ready, including when enable goes low.
REQ-026 When enable=0 in IDLE, APPLY or RELEASE:
- entry_value, digits_bcd and digit_count SHALL clear;
- the FSM SHALL go to RELEASE;
- key_ack and err SHALL not pulse.
REQ-027 A key held down SHALL be accepted exactly once per press.
REQ-028 Maximum key throughput: one key per 2+RELEASE_CYCLES cycles.

Reset
REQ-029 While reset_n=0 the block SHALL be asynchronously forced to:
- FSM state IDLE;
- all outputs 0;
- release counter and registered key 0.
REQ-030 Reset asserted mid-entry or during HOLD SHALL discard the pending entry with no ack or err pulse.

Structure
REQ-031 A shared package SHALL hold:
- key code constants KEY_STAR=10, KEY_HASH=11, KEY_IDLE=13;
- the FSM state encoding.
REQ-032 One sub-module, entry_accum, SHALL hold the value, BCD and count registers and implement the digit, clear and overflow operations; the top level SHALL contain the FSM and the release counter.

Verification
REQ-033 Keys 4,2,7,'#' each held 3 cycles with ≥4 idle cycles between them, then entry_ready held high:
- one key_ack per key;
- entry_valid=1 with entry_value=427, digits_bcd low 12 bits=0x427, digit_count=3;
- after the handshake, all cleared.
REQ-034 Seven digits '9' then '#': first six accepted; the 7th acks with an err pulse; entry_value=999999.
REQ-035 Keys 5,'*',3,'#': entry_value=3, digit_count=1.
REQ-036 Timing and empty-entry checks:
- '#' on an empty entry → ack, err pulse, entry_valid stays 0;
- digit 8 held 20 cycles → exactly one key_ack;
- key bounces idle/8 within fewer than RELEASE_CYCLES idle cycles → no second ack.
REQ-037 Hold checks:
- in HOLD with entry_ready=0, pressing 1 and dropping enable → no ack, entry_valid stays 1 and entry_value is unchanged until entry_ready.
REQ-038 Reset checks:
- reset_n pulsed low after digits 1,2 → all outputs 0 immediately (asynchronous);
- a fresh entry afterwards works normally.

Source files
------------

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared key codes, FSM encoding and accumulator opcodes for the keypad entry controller.
package keypad_entry_ctrl_pkg;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;
   localparam logic [3:0] KEY_IDLE = 4'd13;

   typedef enum logic [1:0] {IDLE, APPLY, RELEASE, HOLD} state_e;

   typedef enum logic [1:0] {ACC_NOP, ACC_DIGIT, ACC_CLEAR} acc_op_e;

   // Codes 0-11 are real keys; anything else reads as idle.
   function automatic logic is_key(input logic [3:0] code);
      return code <= KEY_HASH;
   endfunction

endpackage

// File: rtl/keypad_entry_ctrl_entry_accum.sv
// Entry accumulator: binary value, BCD display digits and digit count.
module entry_accum
   import keypad_entry_ctrl_pkg::*;
#(
   parameter int MAX_DIGITS = 6,
   parameter int VALUE_W    = 20,
   parameter int CNT_W      = 3
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  acc_op_e                   op_i,
   input  logic [3:0]                digit_i,
   output logic [VALUE_W-1:0]        value_o,
   output logic [4*MAX_DIGITS-1:0]   bcd_o,
   output logic [CNT_W-1:0]          count_o,
   output logic                      ovf_o
);

   localparam int BCD_W = 4*MAX_DIGITS;

   logic [VALUE_W-1:0] value_q, value_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full;

   assign full  = (count_q == CNT_W'(MAX_DIGITS));
   assign ovf_o = (op_i == ACC_DIGIT) && full;

   always_comb begin
      value_d = value_q;
      bcd_d   = bcd_q;
      count_d = count_q;
      case (op_i)
         ACC_DIGIT: if (!full) begin
            // x*10 = x*8 + x*2
            value_d = (value_q << 3) + (value_q << 1) + VALUE_W'(digit_i);
            bcd_d   = (bcd_q << 4) | BCD_W'(digit_i);
            count_d = count_q + CNT_W'(1);
         end
         ACC_CLEAR: begin
            value_d = '0;
            bcd_d   = '0;
            count_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
         bcd_q   <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
      end
   end

   assign value_o = value_q;
   assign bcd_o   = bcd_q;
   assign count_o = count_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: press/release FSM around an entry accumulator with a valid/ready handoff.
module keypad_entry_ctrl
   import keypad_entry_ctrl_pkg::*;
#(
   parameter int MAX_DIGITS     = 6,
   parameter int VALUE_W        = 20,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [3:0]                        key_code,
   input  logic                              enable,
   input  logic                              entry_ready,
   output logic                              key_ack,
   output logic                              entry_valid,
   output logic [VALUE_W-1:0]                entry_value,
   output logic [4*MAX_DIGITS-1:0]           digits_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
   output logic                              err
);

   localparam int CNT_W = $clog2(MAX_DIGITS+1);
   localparam int RC_W  = $clog2(RELEASE_CYCLES+1);

   state_e           state_q, state_d;
   logic [3:0]       key_q, key_d;
   logic [RC_W-1:0]  rel_cnt_q, rel_cnt_d;
   acc_op_e          op;
   logic             ovf;

   entry_accum #(
      .MAX_DIGITS (MAX_DIGITS),
      .VALUE_W    (VALUE_W),
      .CNT_W      (CNT_W)
   ) u_accum (
      .clock   (clock),
      .reset_n (reset_n),
      .op_i    (op),
      .digit_i (key_q),
      .value_o (entry_value),
      .bcd_o   (digits_bcd),
      .count_o (digit_count),
      .ovf_o   (ovf)
   );

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      rel_cnt_d   = rel_cnt_q;
      op          = ACC_NOP;
      key_ack     = 1'b0;
      err         = 1'b0;
      entry_valid = 1'b0;
      case (state_q)
         IDLE, APPLY: begin
            if (!enable) begin
               op        = ACC_CLEAR;
               state_d   = RELEASE;
               rel_cnt_d = '0;
            end else if (state_q == IDLE) begin
               if (is_key(key_code)) begin
                  key_d   = key_code;
                  state_d = APPLY;
               end
            end else begin
               key_ack   = 1'b1;
               state_d   = RELEASE;
               rel_cnt_d = '0;
               if (key_q <= 4'd9) begin
                  op  = ACC_DIGIT;
                  err = ovf;
               end else if (key_q == KEY_STAR) begin
                  op = ACC_CLEAR;
               end else if (digit_count != '0) begin
                  state_d = HOLD;
               end else begin
                  err = 1'b1;
               end
            end
         end
         RELEASE: begin
            // Only an unbroken run of idle cycles counts as a release.
            if (!enable) begin
               op        = ACC_CLEAR;
               rel_cnt_d = '0;
            end else if (is_key(key_code)) begin
               rel_cnt_d = '0;
            end else if (rel_cnt_q == RC_W'(RELEASE_CYCLES-1)) begin
               rel_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               rel_cnt_d = rel_cnt_q + RC_W'(1);
            end
         end
         HOLD: begin
            entry_valid = 1'b1;
            if (entry_ready) begin
               op        = ACC_CLEAR;
               state_d   = RELEASE;
               rel_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         key_q     <= '0;
         rel_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         rel_cnt_q <= rel_cnt_d;
      end
   end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboarded bench for keypad_entry_ctrl: expected acks/entries queued at stimulus, checked by a monitor.
module tb_keypad_entry_ctrl;

   localparam int MD = 6;
   localparam int VW = 20;
   localparam int RC = 4;
   localparam int CW = 3;
   localparam int BW = 4*MD;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    key_code = 4'd13;
   logic          enable = 1'b0;
   logic          entry_ready = 1'b0;
   logic          key_ack, entry_valid, err;
   logic [VW-1:0] entry_value;
   logic [BW-1:0] digits_bcd;
   logic [CW-1:0] digit_count;

   keypad_entry_ctrl #(.MAX_DIGITS(MD), .VALUE_W(VW), .RELEASE_CYCLES(RC)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .key_code    (key_code),
      .enable      (enable),
      .entry_ready (entry_ready),
      .key_ack     (key_ack),
      .entry_valid (entry_valid),
      .entry_value (entry_value),
      .digits_bcd  (digits_bcd),
      .digit_count (digit_count),
      .err         (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [VW-1:0] value;
      logic [BW-1:0] bcd;
      logic [CW-1:0] count;
   } entry_t;

   bit     exp_ack[$];
   entry_t exp_entry[$];
   int     checks = 0;
   int     errors = 0;
   int     ack_seen = 0;
   logic   ev_prev = 1'b0;
   bit     exp_e;
   entry_t exp_x;

   // Monitor: every ack pops an expected err flag, every rising entry_valid pops an expected entry.
   always @(negedge clock) begin
      if (reset_n) begin
         if (key_ack) begin
            ack_seen++;
            checks++;
            if (exp_ack.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack got key_ack=1 want 0");
            end else begin
               exp_e = exp_ack.pop_front();
               if (err !== exp_e) begin
                  errors++;
                  $display("FAIL ack_err got %0b want %0b", err, exp_e);
               end
            end
         end else if (err) begin
            checks++;
            errors++;
            $display("FAIL err_without_ack got err=1 want 0");
         end
         if (entry_valid && !ev_prev) begin
            checks++;
            if (exp_entry.size() == 0) begin
               errors++;
               $display("FAIL unexpected_entry got entry_valid=1 want 0");
            end else begin
               exp_x = exp_entry.pop_front();
               if (entry_value !== exp_x.value) begin
                  errors++;
                  $display("FAIL entry_value got %0d want %0d", entry_value, exp_x.value);
               end
               checks++;
               if (digits_bcd !== exp_x.bcd) begin
                  errors++;
                  $display("FAIL entry_bcd got %h want %h", digits_bcd, exp_x.bcd);
               end
               checks++;
               if (digit_count !== exp_x.count) begin
                  errors++;
                  $display("FAIL entry_count got %0d want %0d", digit_count, exp_x.count);
               end
            end
         end
      end
      ev_prev = entry_valid;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold, input int gap);
      key_code = code;
      cyc(hold);
      key_code = 4'd13;
      cyc(gap);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 60 && !entry_valid; i++) cyc(1);
      checks++;
      if (entry_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_valid_timeout got %b want 1", entry_valid);
      end
   endtask

   task automatic handshake();
      entry_ready = 1'b1;
      for (int i = 0; i < 20 && entry_valid; i++) cyc(1);
      checks++;
      if ({entry_valid, entry_value, digits_bcd, digit_count} !== '0) begin
         errors++;
         $display("FAIL handshake_clear got v=%b val=%0d bcd=%h cnt=%0d want all 0",
                  entry_valid, entry_value, digits_bcd, digit_count);
      end
      entry_ready = 1'b0;
      cyc(RC + 3);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc(2);
      checks++;
      if ({key_ack, err, entry_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000", {key_ack, err, entry_valid});
      end
      checks++;
      if ({entry_value, digits_bcd, digit_count} !== '0) begin
         errors++;
         $display("FAIL reset_data got val=%0d bcd=%h cnt=%0d want 0", entry_value, digits_bcd, digit_count);
      end
      enable = 1'b1;
      reset_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_basic();
      repeat (4) exp_ack.push_back(1'b0);
      exp_entry.push_back('{value: 20'd427, bcd: 24'h000427, count: 3'd3});
      press(4'd4, 3, 6);
      press(4'd2, 3, 6);
      press(4'd7, 3, 6);
      press(4'd11, 3, 2);
      wait_valid();
      handshake();
      checks++;
      if (exp_ack.size() != 0 || exp_entry.size() != 0) begin
         errors++;
         $display("FAIL basic_drain got acks=%0d entries=%0d left want 0", exp_ack.size(), exp_entry.size());
      end
   endtask

   task automatic test_overflow();
      repeat (6) exp_ack.push_back(1'b0);
      exp_ack.push_back(1'b1);
      exp_ack.push_back(1'b0);
      exp_entry.push_back('{value: 20'd999999, bcd: 24'h999999, count: 3'd6});
      repeat (7) press(4'd9, 3, 6);
      press(4'd11, 3, 2);
      wait_valid();
      handshake();
      checks++;
      if (exp_ack.size() != 0 || exp_entry.size() != 0) begin
         errors++;
         $display("FAIL overflow_drain got acks=%0d entries=%0d left want 0", exp_ack.size(), exp_entry.size());
      end
   endtask

   task automatic test_star();
      repeat (4) exp_ack.push_back(1'b0);
      exp_entry.push_back('{value: 20'd3, bcd: 24'h000003, count: 3'd1});
      press(4'd5, 3, 6);
      press(4'd10, 3, 6);
      press(4'd3, 3, 6);
      press(4'd11, 3, 2);
      wait_valid();
      handshake();
      checks++;
      if (exp_ack.size() != 0 || exp_entry.size() != 0) begin
         errors++;
         $display("FAIL star_drain got acks=%0d entries=%0d left want 0", exp_ack.size(), exp_entry.size());
      end
   endtask

   task automatic test_empty_hash();
      exp_ack.push_back(1'b1);
      press(4'd11, 3, 8);
      checks++;
      if (entry_valid !== 1'b0 || digit_count !== '0) begin
         errors++;
         $display("FAIL empty_hash got v=%b cnt=%0d want v=0 cnt=0", entry_valid, digit_count);
      end
      checks++;
      if (exp_ack.size() != 0) begin
         errors++;
         $display("FAIL empty_hash_drain got %0d acks left want 0", exp_ack.size());
      end
   endtask

   task automatic test_bounce();
      int a0;
      a0 = ack_seen;
      exp_ack.push_back(1'b0);
      key_code = 4'd8;
      cyc(20);
      repeat (3) begin
         key_code = 4'd13;
         cyc(RC - 2);
         key_code = 4'd8;
         cyc(2);
      end
      key_code = 4'd13;
      cyc(RC + 3);
      checks++;
      if (ack_seen - a0 != 1) begin
         errors++;
         $display("FAIL bounce_acks got %0d want 1", ack_seen - a0);
      end
      checks++;
      if (entry_value !== 20'd8 || digit_count !== 3'd1) begin
         errors++;
         $display("FAIL bounce_value got val=%0d cnt=%0d want 8/1", entry_value, digit_count);
      end
      exp_ack.push_back(1'b0);
      press(4'd10, 3, 6);
      checks++;
      if (digit_count !== '0 || exp_ack.size() != 0) begin
         errors++;
         $display("FAIL bounce_clear got cnt=%0d left=%0d want 0/0", digit_count, exp_ack.size());
      end
   endtask

   task automatic test_hold();
      repeat (2) exp_ack.push_back(1'b0);
      exp_entry.push_back('{value: 20'd6, bcd: 24'h000006, count: 3'd1});
      press(4'd6, 3, 6);
      press(4'd11, 3, 2);
      wait_valid();
      press(4'd1, 3, 3);
      enable = 1'b0;
      cyc(5);
      checks++;
      if (entry_valid !== 1'b1 || entry_value !== 20'd6 || digit_count !== 3'd1) begin
         errors++;
         $display("FAIL hold_stable got v=%b val=%0d cnt=%0d want 1/6/1", entry_valid, entry_value, digit_count);
      end
      enable = 1'b1;
      cyc(2);
      checks++;
      if (entry_valid !== 1'b1 || entry_value !== 20'd6) begin
         errors++;
         $display("FAIL hold_reenable got v=%b val=%0d want 1/6", entry_valid, entry_value);
      end
      handshake();
      checks++;
      if (exp_ack.size() != 0 || exp_entry.size() != 0) begin
         errors++;
         $display("FAIL hold_drain got acks=%0d entries=%0d left want 0", exp_ack.size(), exp_entry.size());
      end
   endtask

   task automatic test_reset_mid();
      repeat (2) exp_ack.push_back(1'b0);
      press(4'd1, 3, 6);
      press(4'd2, 3, 2);
      checks++;
      if (digit_count !== 3'd2 || entry_value !== 20'd12) begin
         errors++;
         $display("FAIL mid_pre got cnt=%0d val=%0d want 2/12", digit_count, entry_value);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({key_ack, err, entry_valid, entry_value, digits_bcd, digit_count} !== '0) begin
         errors++;
         $display("FAIL async_reset got val=%0d bcd=%h cnt=%0d flags=%b want all 0",
                  entry_value, digits_bcd, digit_count, {key_ack, err, entry_valid});
      end
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      repeat (2) exp_ack.push_back(1'b0);
      exp_entry.push_back('{value: 20'd3, bcd: 24'h000003, count: 3'd1});
      press(4'd3, 3, 6);
      press(4'd11, 3, 2);
      wait_valid();
      handshake();
      checks++;
      if (exp_ack.size() != 0 || exp_entry.size() != 0) begin
         errors++;
         $display("FAIL mid_drain got acks=%0d entries=%0d left want 0", exp_ack.size(), exp_entry.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_star();
      test_empty_hash();
      test_bounce();
      test_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
